// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port, fixed-latency synchronous data memory.
// Define DMEM_ARB_ERR_EN to add p_err/l_err misaligned-access reporting.
`timescale 1ns/1ps
module dmem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LAT      = 2,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic [DATA_W-1:0] p_rdata,
   output logic              p_done,
   output logic              stall_m,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic [DATA_W-1:0] l_rdata,
   output logic              l_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              owner
`ifdef DMEM_ARB_ERR_EN
   ,
   output logic              p_err,
   output logic              l_err
`endif
);

   localparam int LAT_W = $clog2(MEM_LAT + 1);
   localparam int SW    = $clog2(STARVE_LIMIT + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]        state;
   logic [LAT_W-1:0]  lat_cnt;
   logic [SW-1:0]     starve_cnt;
   logic              grant_l;
   logic              any_req;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              misalign;

   // L wins only when alone or when P has been granted STARVE_LIMIT times while L waited
   assign any_req   = p_req | l_req;
   assign grant_l   = l_req & (~p_req | (starve_cnt == SW'(STARVE_LIMIT)));
   assign win_we    = grant_l ? l_we    : p_we;
   assign win_addr  = grant_l ? l_addr  : p_addr;
   assign win_wdata = grant_l ? l_wdata : p_wdata;

`ifdef DMEM_ARB_ERR_EN
   logic misalign_q;
   assign misalign = misalign_q;
   assign p_err    = p_done & misalign_q;
   assign l_err    = l_done & misalign_q;
`else
   assign misalign = 1'b0;
`endif

   assign mem_en  = (state == S_ACCESS) & ~misalign;
   assign p_done  = (state == S_DONE) & ~owner;
   assign l_done  = (state == S_DONE) & owner;
   assign stall_m = p_req & ~p_done;

   // Main sequencer: grant in IDLE, strobe in ACCESS, count latency in WAIT, pulse in DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         owner      <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         p_rdata    <= '0;
         l_rdata    <= '0;
`ifdef DMEM_ARB_ERR_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  state     <= S_ACCESS;
                  owner     <= grant_l;
                  mem_we    <= win_we;
                  mem_addr  <= win_addr;
                  mem_wdata <= win_wdata;
`ifdef DMEM_ARB_ERR_EN
                  misalign_q <= (win_addr[1:0] != 2'b00);
`endif
                  if (grant_l || !l_req)
                     starve_cnt <= '0;
                  else if (starve_cnt != SW'(STARVE_LIMIT))
                     starve_cnt <= starve_cnt + SW'(1);
               end
            end
            S_ACCESS: begin
               if (misalign) begin
                  state <= S_DONE;
               end else begin
                  lat_cnt <= LAT_W'(MEM_LAT);
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (lat_cnt == LAT_W'(1)) begin
                  if (!mem_we) begin
                     if (owner)
                        l_rdata <= mem_rdata;
                     else
                        p_rdata <= mem_rdata;
                  end
                  state <= S_DONE;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
